// File: rtl/projectile_slot_arbiter_if.sv
// Bundle of fire-request, grant, release and pool-status signals for projectile_slot_arbiter.
// master = fire sources / collision logic, slave = the arbiter.
interface projectile_slot_arbiter_if #(
    parameter int MAX_PROJ = 10,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 5
);
    // Handshake: reqN is a level request. gnt_idx is valid only in a cycle where gnt0 or gnt1 is high.
    // A grant only appears if the requester did not also get one in the previous cycle.
    // rel_valid/rel_idx is a one-cycle strobe that is always accepted (there is no ready).
    logic                clear_all;
    logic                req0;
    logic                req1;
    logic                gnt0;
    logic                gnt1;
    logic [IDX_W-1:0]    gnt_idx;
    logic                rel_valid;
    logic [IDX_W-1:0]    rel_idx;
    logic [MAX_PROJ-1:0] active;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                rel_err;
    logic [15:0]         drop_cnt;
    logic                rr_dbg;

    modport master (
        output clear_all, req0, req1, rel_valid, rel_idx,
        input  gnt0, gnt1, gnt_idx, active, count, full, rel_err, drop_cnt, rr_dbg
    );

    modport slave (
        input  clear_all, req0, req1, rel_valid, rel_idx,
        output gnt0, gnt1, gnt_idx, active, count, full, rel_err, drop_cnt, rr_dbg
    );
endinterface

// File: rtl/projectile_slot_arbiter.sv
// Projectile slot pool: lowest-free-slot allocation shared round-robin by player/enemy fire.
// Optional stall statistics on drop_cnt are enabled with `define PROJ_ARB_STATS_EN.
module projectile_slot_arbiter #(
    parameter int MAX_PROJ = 10,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 5
) (
    input logic                      CLOCK_50,
    input logic                      resetn,
    projectile_slot_arbiter_if.slave bus
);
    typedef enum logic {FAV_REQ0 = 1'b0, FAV_REQ1 = 1'b1} rr_t;

    rr_t                 rr_q;
    logic [MAX_PROJ-1:0] active_q;
    logic [CNT_W-1:0]    count_q;
    logic                full_q;
    logic                gnt0_q;
    logic                gnt1_q;
    logic [IDX_W-1:0]    gnt_idx_q;
    logic                rel_err_q;

    logic                elig0;
    logic                elig1;
    logic                have_free;
    logic [IDX_W-1:0]    free_idx;
    logic                grant;
    logic                win0;
    logic [MAX_PROJ-1:0] grant_mask;
    logic [MAX_PROJ-1:0] rel_mask;
    logic                rel_hit;
    logic                rel_bad;
    logic [MAX_PROJ-1:0] active_nxt;
    logic [CNT_W-1:0]    count_nxt;

    // A requester that was granted last cycle sits out one edge so a held req cannot double-allocate.
    assign elig0 = bus.req0 & ~gnt0_q;
    assign elig1 = bus.req1 & ~gnt1_q;

    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = MAX_PROJ - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    assign grant      = have_free & (elig0 | elig1);
    assign win0       = elig0 & (~elig1 | (rr_q == FAV_REQ0));
    assign grant_mask = grant ? (MAX_PROJ'(1) << free_idx) : '0;

    // Out-of-range indices simply match no bit, so they fall into the error case.
    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < MAX_PROJ; i++) begin
            if (bus.rel_valid && (32'(bus.rel_idx) == 32'(i)) && active_q[i]) begin
                rel_mask[i] = 1'b1;
            end
        end
    end

    assign rel_hit    = |rel_mask;
    assign rel_bad    = bus.rel_valid & ~rel_hit;
    assign active_nxt = (active_q | grant_mask) & ~rel_mask;
    assign count_nxt  = count_q + CNT_W'(grant) - CNT_W'(rel_hit);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rr_q      <= FAV_REQ0;
            active_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            gnt_idx_q <= '0;
            rel_err_q <= 1'b0;
        end else if (bus.clear_all) begin
            active_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
        end else begin
            active_q <= active_nxt;
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CNT_W'(MAX_PROJ));
            gnt0_q   <= grant & win0;
            gnt1_q   <= grant & ~win0;
            if (grant) begin
                gnt_idx_q <= free_idx;
                rr_q      <= win0 ? FAV_REQ1 : FAV_REQ0;
            end
            if (rel_bad) begin
                rel_err_q <= 1'b1;
            end
        end
    end

`ifdef PROJ_ARB_STATS_EN
    logic [15:0] drop_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            drop_q <= '0;
        end else if (bus.clear_all) begin
            drop_q <= '0;
        end else if (!have_free && (elig0 | elig1) && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.active  = active_q;
    assign bus.count   = count_q;
    assign bus.full    = full_q;
    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.rel_err = rel_err_q;
    assign bus.rr_dbg  = rr_q;
endmodule

// File: tb/tb_projectile_slot_arbiter.sv
// Self-checking bench for projectile_slot_arbiter: directed literal checks plus random traffic
// compared every cycle against a slot-pool model built from arrays and plain counting.
module tb_projectile_slot_arbiter;
    localparam int MAX_PROJ = 10;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 5;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;

    projectile_slot_arbiter_if #(.MAX_PROJ(MAX_PROJ), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus();

    projectile_slot_arbiter #(.MAX_PROJ(MAX_PROJ), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit array of occupied slots, a favoured-requester number, last grants.
    logic [MAX_PROJ-1:0] m_active;
    int m_favour, m_idx, m_free, m_ri, m_drop;
    bit m_g0, m_g1, m_e0, m_e1, m_err;

    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            m_active = '0; m_favour = 0; m_g0 = 0; m_g1 = 0; m_idx = 0; m_err = 0; m_drop = 0;
        end else if (bus.clear_all) begin
            m_active = '0; m_g0 = 0; m_g1 = 0; m_drop = 0;
        end else begin
            m_free = -1;
            for (int i = MAX_PROJ - 1; i >= 0; i--) if (!m_active[i]) m_free = i;
            m_e0 = bus.req0 && !m_g0;
            m_e1 = bus.req1 && !m_g1;
            m_g0 = 0;
            m_g1 = 0;
            if (m_free >= 0 && (m_e0 || m_e1)) begin
                if (m_e0 && !(m_e1 && m_favour == 1)) begin m_g0 = 1; m_favour = 1; end
                else begin m_g1 = 1; m_favour = 0; end
                m_idx = m_free;
            end
`ifdef PROJ_ARB_STATS_EN
            if (m_free < 0 && (m_e0 || m_e1) && m_drop < 65535) m_drop++;
`endif
            if (bus.rel_valid) begin
                m_ri = int'(bus.rel_idx);
                if (m_ri < MAX_PROJ && m_active[m_ri]) m_active[m_ri] = 1'b0;
                else m_err = 1;
            end
            if (m_g0 || m_g1) m_active[m_idx] = 1'b1;
        end
    end

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            check("gnt0", bus.gnt0, m_g0);
            check("gnt1", bus.gnt1, m_g1);
            if (m_g0 || m_g1) check("gnt_idx", bus.gnt_idx, m_idx);
            check("active", bus.active, m_active);
            check("count", bus.count, $countones(m_active));
            check("full", bus.full, $countones(m_active) == MAX_PROJ);
            check("rel_err", bus.rel_err, m_err);
            check("drop_cnt", bus.drop_cnt, m_drop);
        end
    end

    task automatic drive(input bit r0, input bit r1, input bit rv, input int ri, input bit ca);
        bus.req0 = r0; bus.req1 = r1; bus.rel_valid = rv; bus.rel_idx = IDX_W'(ri); bus.clear_all = ca;
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        #2 resetn = 1'b0;
        @(negedge CLOCK_50);
        #2 resetn = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge CLOCK_50);
        chk_en = 1'b1;
        #2 resetn = 1'b1;

        // Reset state
        step();
        check("reset_active", bus.active, 0);
        check("reset_count", bus.count, 0);
        check("reset_gnt0", bus.gnt0, 0);
        check("reset_rel_err", bus.rel_err, 0);

        // Single req0 pulse
        drive(1, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0);
        check("pulse_gnt0", bus.gnt0, 1);
        check("pulse_idx", bus.gnt_idx, 0);
        check("pulse_active", bus.active, 10'b0000000001);
        check("pulse_count", bus.count, 1);

        // Both held from reset: grants alternate 0,1,0,1 on consecutive slots
        do_reset();
        drive(1, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("alt_gnt0", bus.gnt0, (k % 2 == 0));
            check("alt_gnt1", bus.gnt1, (k % 2 == 1));
            check("alt_idx", bus.gnt_idx, k);
        end

        // Fill the pool, stall req1, release slot 3, then req1 receives slot 3
        do_reset();
        drive(1, 1, 0, 0, 0);
        repeat (10) step();
        check("fill_count", bus.count, 10);
        check("fill_full", bus.full, 1);
        drive(0, 1, 0, 0, 0);
        step(); step();
        check("stall_gnt1", bus.gnt1, 0);
        check("stall_full", bus.full, 1);
        drive(0, 1, 1, 3, 0); step();
        check("rel3_count", bus.count, 9);
        check("rel3_gnt1", bus.gnt1, 0);
        drive(0, 1, 0, 0, 0); step();
        check("regrant_gnt1", bus.gnt1, 1);
        check("regrant_idx", bus.gnt_idx, 3);
        check("regrant_count", bus.count, 10);
        drive(0, 0, 0, 0, 0); step();

        // Simultaneous release of slot 0 and grant: allocation sees the pre-release vector
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0); step();
            drive(0, 0, 0, 0, 0); step();
        end
        drive(1, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        check("swap_idx", bus.gnt_idx, 3);
        check("swap_count", bus.count, 3);
        check("swap_active", bus.active, 10'b0000001110);

        // Bad releases set the sticky error, which survives clear_all
        drive(0, 0, 1, 5, 0); step();
        drive(0, 0, 1, 12, 0); step();
        drive(0, 0, 0, 0, 0);
        check("relerr_flag", bus.rel_err, 1);
        check("relerr_active", bus.active, 10'b0000001110);
        drive(0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0);
        check("clear_rel_err", bus.rel_err, 1);
        check("clear_active", bus.active, 0);
        check("clear_count", bus.count, 0);
        check("clear_drop", bus.drop_cnt, 0);

        // Async reset while a grant is visible drops it at once
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        check("pre_rst_gnt0", bus.gnt0, 1);
        #2 resetn = 1'b0;
        #1;
        check("async_gnt0", bus.gnt0, 0);
        check("async_active", bus.active, 0);
        @(negedge CLOCK_50);
        #2 resetn = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            drive($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, MAX_PROJ - 1),
                  ($urandom_range(0, 99) == 0));
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
